axi_slv_mem_resp: RTL
=====================

// Module: axi_slv_mem_resp
// PURPOSE
// - Synthesizable, parametrised AXI3 slave memory responder. Sits on the slave side of the master interface as the DUT-side target.
// - Services one write burst and one read burst concurrently (independent FSMs): FIXED/INCR/WRAP, awlen/arlen up to 255, byte strobes, OKAY/SLVERR responses.
// PARAMETERS
// - ADDR_WIDTH  32    address bus width
// - DATA_WIDTH  32    data bus width (8..1024, power of 2); STRB_W = DATA_WIDTH/8
// - ID_WIDTH    4     awid/wid/bid/arid/rid width
// - MEM_DEPTH   1024  memory words of DATA_WIDTH; byte span = MEM_DEPTH*STRB_W
// PORTS
// - aclk     in   1           clock, all logic on posedge
// - areset   in   1           asynchronous active-high reset
// - awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
// - awvalid  in   1;  awready  out  1
// - wid      in   ID_WIDTH  ignored; wdata in DATA_WIDTH; wstrb in STRB_W; wlast in 1; wvalid in 1; wready out 1
// - bid      out  ID_WIDTH; bresp out 2; bvalid out 1; bready in 1
// - arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
// - arvalid  in   1;  arready  out  1
// - rid      out  ID_WIDTH; rdata out DATA_WIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1
// BEHAVIOUR
// - Reset: every output 0; FSMs to IDLE. Memory contents are NOT reset. Reset mid-burst aborts it, with no response issued.
// - All outputs are registered. awready/arready rise on the first clock edge after areset falls.
// - Write FSM: W_IDLE (awready=1) -> AW handshake latches id/addr/len/size/burst, clears beat cnt/err -> W_DATA (wready=1).
//   - Each W handshake writes the enabled strobe bytes.
//   - When cnt==len, go to W_RESP (bvalid=1, bid=latched awid). On B handshake, return to W_IDLE, awready=1 the next cycle.
// - Read FSM: R_IDLE (arready=1) -> AR handshake -> R_DATA.
//   - rvalid=1 one cycle after the AR handshake.
//   - rdata/rresp/rid are held stable while rvalid && !rready.
//   - rlast=1 when cnt==len. The final R handshake returns to R_IDLE.
// - Address step: FIXED holds the address.
//   - INCR: addr += 1<<size, computed in ADDR_WIDTH bits and wrapping at 2^ADDR_WIDTH.
//   - WRAP: boundary = (len+1)<<size, aligned down; the address wraps to the boundary base.
// - Word index = addr >> log2(STRB_W). Sub-word sized beats use the full bus with wstrb as given; there is no lane steering.
// - SLVERR (2'b10) cases, otherwise OKAY (2'b00):
//   - address >= MEM_DEPTH*STRB_W: the write is dropped; the read returns 0 with per-beat rresp.
//   - size > log2(STRB_W): applies to the whole burst.
//   - burst==2'b11: treated as INCR.
//   - WRAP with len not in {1,3,7,15}: treated as INCR.
// - Write errors are sticky per burst: bresp is SLVERR if any beat erred.
// - wlast mismatch (wlast=1 before cnt==len, or 0 at cnt==len) gives bresp SLVERR. The beat count alone terminates the burst.
// - Simultaneous write and read to the same word in the same cycle: the read returns the old data (read-before-write).
// - Write and read FSMs never block each other. New AW/AR is accepted only in IDLE (one outstanding per direction).
// CONFIGURATION
// - AXI_SLV_MEM_RESP_BP_EN defined: adds an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset; steps every cycle).
//   - When lfsr[1:0]==2'b00, wready is deasserted in W_DATA.
//   - When lfsr[1:0]==2'b00 and no beat is pending, the next rvalid is withheld in R_DATA.
//   - An asserted rvalid is never dropped before its handshake.
// - Undefined: wready is constantly 1 in W_DATA, and rvalid issues back-to-back.
// TESTING
// - Reset: areset=1 for 3 cycles, then 0 -> all outputs 0 during reset; awready=arready=1 one edge later.
// - INCR write: awaddr=0x10, awlen=3, awsize=2, wdata=0xA0..0xA3, wstrb=4'hF, wlast on 4th beat -> bresp=0, bid=awid.
//   - INCR read-back: araddr=0x10, arlen=3 -> rdata 0xA0..0xA3, rlast on beat 3 only.
// - WRAP: araddr=0x18, arlen=3, arsize=2, arburst=2'b10 -> words read at 0x18, 0x1C, 0x10, 0x14.
// - Error: awaddr=MEM_DEPTH*4, awlen=0 -> bresp=2'b10, memory unchanged.
//   - Error: wlast=1 on beat 1 of a len=3 burst -> bresp=2'b10.
// - Concurrency and backpressure: write 0x55 to 0x40 while reading 0x40 in the same cycle -> rdata is the old value.
//   - Backpressure: hold rready=0 for 5 cycles -> rdata/rlast stable; areset pulse mid-read -> rvalid=0, R_IDLE.
// - With AXI_SLV_MEM_RESP_BP_EN: 256-beat INCR write/read -> data intact, stall cycles match the LFSR model.

Source files
------------

// File: rtl/axi_slv_mem_resp.sv
// AXI3 slave memory responder: one write and one read burst serviced concurrently.
// Define AXI_SLV_MEM_RESP_BP_EN to add LFSR-driven wready/rvalid backpressure.
module axi_slv_mem_resp #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_WORDS = ADDR_WIDTH'(MEM_DEPTH);

  function automatic logic oob(input logic [ADDR_WIDTH-1:0] a);
    return (a >> OFFS) >= MEM_WORDS;
  endfunction

  function automatic logic [IDX_W-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> OFFS;
    return w[IDX_W-1:0];
  endfunction

  // Reserved bursts and WRAP with an illegal length both step as INCR.
  function automatic logic [1:0] eff_burst(input logic [1:0] b, input logic [7:0] len);
    if (b == 2'b00) return 2'b00;
    if (b == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic burst_err(input logic [2:0] sz, input logic [1:0] b,
                                     input logic [7:0] len);
    return (32'(sz) > OFFS) || (b == 2'b11) || (b == 2'b10 && eff_burst(b, len) != 2'b10);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a,
                                                 input logic [2:0] sz, input logic [7:0] len,
                                                 input logic [1:0] b);
    logic [ADDR_WIDTH-1:0] inc, msk;
    inc = ADDR_WIDTH'(1) << sz;
    msk = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    case (b)
      2'b00:   return a;
      2'b10:   return (a & ~msk) | ((a + inc) & msk);
      default: return a + inc;
    endcase
  endfunction

  logic bp_stall;
`ifdef AXI_SLV_MEM_RESP_BP_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
  // Registered handshake outputs see the LFSR value that will be current next cycle.
  assign bp_stall = (lfsr_d[1:0] == 2'b00);
`else
  assign bp_stall = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write channel
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d, bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d, bresp_q, bresp_d;
  logic                  w_err_q, w_err_d, awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d, mem_we;
  logic                  aw_hs, w_hs, b_hs;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;
  assign b_hs  = bvalid_q & bready;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: if (aw_hs) begin
        w_id_d    = awid;
        w_addr_d  = awaddr;
        w_len_d   = awlen;
        w_size_d  = awsize;
        w_burst_d = eff_burst(awburst, awlen);
        w_err_d   = burst_err(awsize, awburst, awlen);
        w_cnt_d   = 8'd0;
        w_state_d = WData;
      end
      WData: if (w_hs) begin
        mem_we  = ~oob(w_addr_q);
        w_err_d = w_err_q | oob(w_addr_q) | (wlast != (w_cnt_q == w_len_q));
        if (w_cnt_q == w_len_q) begin
          w_state_d = WResp;
          bvalid_d  = 1'b1;
          bid_d     = w_id_q;
          bresp_d   = w_err_d ? 2'b10 : 2'b00;
        end else begin
          w_cnt_d  = w_cnt_q + 8'd1;
          w_addr_d = step(w_addr_q, w_size_q, w_len_q, w_burst_q);
        end
      end
      WResp: if (b_hs) begin
        bvalid_d  = 1'b0;
        w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
    awready_d = (w_state_d == WIdle);
    wready_d  = (w_state_d == WData) & ~bp_stall;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[widx(w_addr_q)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read channel
  typedef enum logic {RIdle, RData} r_state_e;
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d, rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  r_err_q, r_err_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d, ar_hs, r_hs, ld;

  assign ar_hs = arvalid & arready_q;
  assign r_hs  = rvalid_q & rready;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    ld        = 1'b0;
    unique case (r_state_q)
      RIdle: if (ar_hs) begin
        r_id_d    = arid;
        r_addr_d  = araddr;
        r_len_d   = arlen;
        r_size_d  = arsize;
        r_burst_d = eff_burst(arburst, arlen);
        r_err_d   = burst_err(arsize, arburst, arlen);
        r_cnt_d   = 8'd0;
        r_state_d = RData;
        ld        = 1'b1;
      end
      RData: begin
        if (r_hs) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            r_state_d = RIdle;
          end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = step(r_addr_q, r_size_q, r_len_q, r_burst_q);
            ld       = 1'b1;
          end
        end else if (!rvalid_q) begin
          ld = 1'b1;
        end
      end
    endcase
    // Memory is sampled at the load edge, so a same-cycle write is not yet visible.
    if (ld) begin
      rvalid_d = ~bp_stall;
      rdata_d  = oob(r_addr_d) ? '0 : mem[widx(r_addr_d)];
      rresp_d  = (r_err_d | oob(r_addr_d)) ? 2'b10 : 2'b00;
      rlast_d  = (r_cnt_d == r_len_d);
      rid_d    = r_id_d;
    end
    arready_d = (r_state_d == RIdle);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;

endmodule
